// File: rtl/gon_rr_gather_if.sv
// rtl/gon_rr_gather_if.sv - PE-array and GLB handshake bundle for gon_rr_gather
// master drives PE words and GLB ready; slave is the gather network.
interface gon_rr_gather_if #(
  parameter int NUM_PE    = 48,
  parameter int DATA_BITS = 32
);
  logic [NUM_PE-1:0]           PE_valid;
  logic [NUM_PE-1:0]           PE_ready;
  logic [DATA_BITS*NUM_PE-1:0] PE_data;
  logic                        GON_valid;
  logic                        GON_ready;
  logic [DATA_BITS-1:0]        GON_data;

  modport master (
    output PE_valid, PE_data, GON_ready,
    input  PE_ready, GON_valid, GON_data
  );

  modport slave (
    input  PE_valid, PE_data, GON_ready,
    output PE_ready, GON_valid, GON_data
  );
endinterface

// File: rtl/gon_rr_gather.sv
// rtl/gon_rr_gather.sv - round-robin gather of PE results into an output FIFO for the GLB
// Tag-matched PEs arbitrate every cycle; a burst counter flags the last word of a programmed burst.
module gon_rr_gather #(
  parameter int NUM_ROW    = 6,
  parameter int NUM_COL    = 8,
  parameter int DATA_BITS  = 32,
  parameter int XID_BITS   = 4,
  parameter int YID_BITS   = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_BITS   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set_XID,
  input  logic [XID_BITS-1:0]         XID_scan_in,
  input  logic                        set_YID,
  input  logic [YID_BITS-1:0]         YID_scan_in,
  input  logic [XID_BITS-1:0]         tag_X,
  input  logic [YID_BITS-1:0]         tag_Y,
  input  logic [CNT_BITS-1:0]         burst_len,
  input  logic                        burst_start,
  gon_rr_gather_if.slave              gon,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        burst_done
);

  localparam int NUM_PE   = NUM_ROW * NUM_COL;
  localparam int PTR_BITS = $clog2(NUM_PE);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  localparam logic [PTR_BITS:0]   NUM_PE_W = (PTR_BITS+1)'(NUM_PE);
  localparam logic [PTR_BITS-1:0] LAST_PE  = PTR_BITS'(NUM_PE - 1);
  localparam logic [CW-1:0]       DEPTH_W  = CW'(FIFO_DEPTH);

  // ---------------- ID scan chains ----------------
  logic [XID_BITS-1:0] xid [NUM_PE];
  logic [YID_BITS-1:0] yid [NUM_ROW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_PE; k++) xid[k] <= '0;
      for (int r = 0; r < NUM_ROW; r++) yid[r] <= '0;
    end else begin
      if (set_XID) begin
        xid[0] <= XID_scan_in;
        for (int k = 1; k < NUM_PE; k++) xid[k] <= xid[k-1];
      end
      if (set_YID) begin
        yid[0] <= YID_scan_in;
        for (int r = 1; r < NUM_ROW; r++) yid[r] <= yid[r-1];
      end
    end
  end

  // ---------------- eligibility and word fan-in ----------------
  logic [NUM_PE-1:0]    elig;
  logic [DATA_BITS-1:0] pe_word [NUM_PE];

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      localparam int K = r * NUM_COL + c;
      assign elig[K]    = gon.PE_valid[K] && (yid[r] == tag_Y) && (xid[K] == tag_X);
      assign pe_word[K] = gon.PE_data[K*DATA_BITS +: DATA_BITS];
    end
  end

  // ---------------- FIFO state ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  assign fifo_full = (count == DEPTH_W);

  // ---------------- round-robin arbiter ----------------
  logic [PTR_BITS-1:0] rr_ptr;
  logic                grant_any;
  logic [PTR_BITS-1:0] grant_idx;
  logic [NUM_PE-1:0]   grant;
  logic [PTR_BITS:0]   cand_sum;
  logic [PTR_BITS-1:0] cand;

  // Gating with rst keeps PE_ready low during reset even though tags may match zeroed IDs.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand_sum  = '0;
    cand      = '0;
    if (!fifo_full && !rst) begin
      for (int i = 0; i < NUM_PE; i++) begin
        cand_sum = {1'b0, rr_ptr} + (PTR_BITS+1)'(i);
        if (cand_sum >= NUM_PE_W) cand_sum = cand_sum - NUM_PE_W;
        cand = cand_sum[PTR_BITS-1:0];
        if (!grant_any && elig[cand]) begin
          grant_any = 1'b1;
          grant_idx = cand;
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign gon.PE_ready = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      rr_ptr <= (grant_idx == LAST_PE) ? '0 : grant_idx + PTR_BITS'(1);
    end
  end

  // ---------------- output FIFO ----------------
  assign push = grant_any;
  assign pop  = gon.GON_valid && gon.GON_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pe_word[grant_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign gon.GON_valid = (count != '0);
  assign gon.GON_data  = gon.GON_valid ? mem[rd_ptr] : '0;
  assign fifo_count    = count;

  // ---------------- burst counter ----------------
  typedef enum logic {B_IDLE, B_ARMED} burst_state_t;

  burst_state_t        state;
  burst_state_t        state_nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_nxt;
  logic                done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= B_IDLE;
      cnt        <= '0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      burst_done <= done_nxt;
    end
  end

  // A start overrides any pop in the same cycle; a zero-length burst finishes at once.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (burst_start) begin
      cnt_nxt = '0;
      if (burst_len == '0) begin
        state_nxt = B_IDLE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = B_ARMED;
      end
    end else if (state == B_ARMED && pop) begin
      cnt_nxt = cnt + CNT_BITS'(1);
      if (cnt == burst_len - CNT_BITS'(1)) begin
        state_nxt = B_IDLE;
        done_nxt  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gon_rr_gather.sv
// tb/tb_gon_rr_gather.sv - self-checking bench for gon_rr_gather
// Vector table for tag matching, hand sequences for backpressure, bursts and async reset.
module tb_gon_rr_gather;

  localparam int NUM_ROW    = 6;
  localparam int NUM_COL    = 8;
  localparam int N          = NUM_ROW * NUM_COL;
  localparam int DATA_BITS  = 32;
  localparam int XID_BITS   = 4;
  localparam int YID_BITS   = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_BITS   = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  set_XID;
  logic [XID_BITS-1:0]   XID_scan_in;
  logic                  set_YID;
  logic [YID_BITS-1:0]   YID_scan_in;
  logic [XID_BITS-1:0]   tag_X;
  logic [YID_BITS-1:0]   tag_Y;
  logic [CNT_BITS-1:0]   burst_len;
  logic                  burst_start;
  logic [2:0]            fifo_count;
  logic                  burst_done;

  gon_rr_gather_if #(.NUM_PE(N), .DATA_BITS(DATA_BITS)) gon ();

  gon_rr_gather #(
    .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .DATA_BITS(DATA_BITS),
    .XID_BITS(XID_BITS), .YID_BITS(YID_BITS),
    .FIFO_DEPTH(FIFO_DEPTH), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst(rst),
    .set_XID(set_XID), .XID_scan_in(XID_scan_in),
    .set_YID(set_YID), .YID_scan_in(YID_scan_in),
    .tag_X(tag_X), .tag_Y(tag_Y),
    .burst_len(burst_len), .burst_start(burst_start),
    .gon(gon),
    .fifo_count(fifo_count), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [DATA_BITS-1:0] sb_q [$];
  logic [DATA_BITS-1:0] cur_base;
  int exp_ptr;

  typedef struct {
    logic [YID_BITS-1:0] ty;
    logic [XID_BITS-1:0] tx;
    int                  drop;
    int                  exp_k;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [DATA_BITS-1:0] base);
    cur_base = base;
    for (int k = 0; k < N; k++) gon.PE_data[k*DATA_BITS +: DATA_BITS] = base + DATA_BITS'(k);
  endtask

  // First value shifted lands at the highest index, so shift from PE N-1 down to 0.
  task automatic scan_ids(input bit zero);
    set_XID = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      XID_scan_in = zero ? '0 : XID_BITS'(k % NUM_COL);
      set_YID     = (k < NUM_ROW);
      YID_scan_in = zero ? '0 : YID_BITS'(k);
      step();
    end
    set_XID = 1'b0;
    set_YID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || fifo_count != 0) && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $display("FAIL drain_timeout: got %0d words left expected 0", sb_q.size());
    end
  endtask

  // Scoreboard consumer: a pop happens at the next rising edge with these inputs.
  always @(negedge clk) begin
    if (!rst && gon.GON_valid && gon.GON_ready) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_pop: got %0h expected no word", gon.GON_data);
      end else begin
        logic [DATA_BITS-1:0] e;
        e = sb_q.pop_front();
        if (gon.GON_data !== e) begin
          fails++;
          $display("FAIL gon_data: got %0h expected %0h", gon.GON_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{ty: 3'd2, tx: 4'd5, drop: -1, exp_k: 21};
    vt[1] = '{ty: 3'd0, tx: 4'd0, drop: -1, exp_k: 0};
    vt[2] = '{ty: 3'd5, tx: 4'd7, drop: -1, exp_k: 47};
    vt[3] = '{ty: 3'd3, tx: 4'd2, drop: -1, exp_k: 26};
    vt[4] = '{ty: 3'd7, tx: 4'd0, drop: -1, exp_k: -1};
    vt[5] = '{ty: 3'd1, tx: 4'd9, drop: -1, exp_k: -1};
    vt[6] = '{ty: 3'd4, tx: 4'd4, drop: 36, exp_k: -1};
    vt[7] = '{ty: 3'd4, tx: 4'd4, drop: -1, exp_k: 36};

    rst = 1'b0; set_XID = 0; set_YID = 0; XID_scan_in = 0; YID_scan_in = 0;
    tag_X = 0; tag_Y = 0; burst_len = 0; burst_start = 0;
    gon.PE_valid = '1; gon.GON_ready = 1'b0;
    set_data(32'h0);
    #1 rst = 1'b1;
    #1;
    chk("rst_gon_valid", gon.GON_valid, 0);
    chk("rst_pe_ready", gon.PE_ready, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_gon_data", gon.GON_data, 0);
    step();
    gon.PE_valid = '0;
    rst = 1'b0;
    step();

    // Tag matching against column/row IDs.
    scan_ids(1'b0);
    set_data(32'hA000_0000);
    gon.GON_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      tag_Y = vt[v].ty;
      tag_X = vt[v].tx;
      gon.PE_valid = '1;
      if (vt[v].drop >= 0) gon.PE_valid[vt[v].drop] = 1'b0;
      #1;
      chk($sformatf("v%0d_pe_ready", v), gon.PE_ready, onehot(vt[v].exp_k));
      if (vt[v].exp_k >= 0) sb_q.push_back(cur_base + DATA_BITS'(vt[v].exp_k));
      step();
      chk($sformatf("v%0d_fifo_count", v), fifo_count, (vt[v].exp_k >= 0) ? 1 : 0);
      if (vt[v].exp_k >= 0)
        chk($sformatf("v%0d_latency_data", v), gon.GON_data, cur_base + DATA_BITS'(vt[v].exp_k));
    end
    gon.PE_valid = '0;
    drain();

    // Multi-match: reset clears IDs and the arbiter pointer.
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    step();
    tag_X = 0; tag_Y = 0;
    set_data(32'h0);
    gon.PE_valid = '1;
    for (int i = 0; i < N; i++) begin
      #1;
      chk($sformatf("mm%0d_pe_ready", i), gon.PE_ready, onehot(i));
      if (i > 0) chk("mm_fifo_count", fifo_count, 1);
      sb_q.push_back(cur_base + DATA_BITS'(i));
      step();
      gon.PE_valid[i] = 1'b0;
    end
    drain();

    // Backpressure with three then five requesters.
    gon.GON_ready = 1'b0;
    set_data(32'h3000_0000);
    gon.PE_valid = '0;
    gon.PE_valid[3] = 1; gon.PE_valid[10] = 1; gon.PE_valid[20] = 1;
    begin
      int g3 [3];
      g3[0] = 3; g3[1] = 10; g3[2] = 20;
      for (int i = 0; i < 3; i++) begin
        #1;
        chk("bp_pe_ready", gon.PE_ready, onehot(g3[i]));
        sb_q.push_back(cur_base + DATA_BITS'(g3[i]));
        step();
        gon.PE_valid[g3[i]] = 1'b0;
        chk("bp_fifo_count", fifo_count, 3'(i + 1));
      end
    end
    #1 chk("bp_idle_ready", gon.PE_ready, 0);
    step();
    chk("bp_hold_count", fifo_count, 3);
    gon.PE_valid[30] = 1; gon.PE_valid[40] = 1;
    #1 chk("bp_4th_ready", gon.PE_ready, onehot(30));
    sb_q.push_back(cur_base + 30);
    step();
    gon.PE_valid[30] = 1'b0;
    chk("bp_full_count", fifo_count, 4);
    #1 chk("bp_full_ready", gon.PE_ready, 0);
    step();
    chk("bp_full_hold", fifo_count, 4);
    gon.GON_ready = 1'b1;
    #1 chk("bp_full_pop_ready", gon.PE_ready, 0);
    step();
    chk("bp_pop_no_push", fifo_count, 3);
    #1 chk("bp_5th_ready", gon.PE_ready, onehot(40));
    sb_q.push_back(cur_base + 40);
    step();
    gon.PE_valid[40] = 1'b0;
    chk("bp_push_pop_count", fifo_count, 3);
    drain();
    exp_ptr = 41;

    // Full FIFO under continuous traffic.
    gon.GON_ready = 1'b0;
    set_data(32'h5000_0000);
    gon.PE_valid = '1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cf_fill_ready", gon.PE_ready, onehot(exp_ptr));
      sb_q.push_back(cur_base + DATA_BITS'(exp_ptr));
      step();
      exp_ptr = (exp_ptr + 1) % N;
    end
    chk("cf_full_count", fifo_count, 4);
    gon.GON_ready = 1'b1;
    #1 chk("cf_full_pop_ready", gon.PE_ready, 0);
    step();
    chk("cf_pop_only_count", fifo_count, 3);
    for (int i = 0; i < 6; i++) begin
      #1 chk("cf_stream_ready", gon.PE_ready, onehot(exp_ptr));
      sb_q.push_back(cur_base + DATA_BITS'(exp_ptr));
      step();
      exp_ptr = (exp_ptr + 1) % N;
      chk("cf_stream_count", fifo_count, 3);
    end
    gon.PE_valid = '0;
    drain();

    // Burst of five words followed by a sixth, uncounted pop.
    set_data(32'h4000_0000);
    burst_len = 16'd5;
    burst_start = 1'b1;
    step();
    burst_start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      gon.PE_valid = (c < 6) ? '1 : '0;
      #1;
      chk($sformatf("burst_c%0d_done", c), burst_done, (c == 6) ? 1 : 0);
      if (c < 6) begin
        chk("burst_ready", gon.PE_ready, onehot(exp_ptr));
        sb_q.push_back(cur_base + DATA_BITS'(exp_ptr));
        exp_ptr = (exp_ptr + 1) % N;
      end
      step();
    end
    drain();
    burst_len = 16'd0;
    burst_start = 1'b1;
    step();
    burst_start = 1'b0;
    chk("burst0_done", burst_done, 1);
    step();
    chk("burst0_done_clear", burst_done, 0);

    // Async reset with three words queued and a burst armed.
    scan_ids(1'b0);
    tag_X = 0; tag_Y = 0;
    set_data(32'h6000_0000);
    gon.GON_ready = 1'b0;
    burst_len = 16'd4;
    burst_start = 1'b1;
    step();
    burst_start = 1'b0;
    gon.PE_valid = '1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ar_fill_ready", gon.PE_ready, onehot(0));
      sb_q.push_back(cur_base);
      step();
    end
    chk("ar_pre_count", fifo_count, 3);
    #1 rst = 1'b1;
    #1;
    chk("ar_gon_valid", gon.GON_valid, 0);
    chk("ar_pe_ready", gon.PE_ready, 0);
    chk("ar_fifo_count", fifo_count, 0);
    chk("ar_gon_data", gon.GON_data, 0);
    sb_q.delete();
    step();
    rst = 1'b0;
    gon.GON_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("ar_post%0d_ready", i), gon.PE_ready, onehot(i));
      chk("ar_no_done", burst_done, 0);
      sb_q.push_back(cur_base + DATA_BITS'(i));
      step();
      gon.PE_valid[i] = 1'b0;
    end
    gon.PE_valid = '0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("ar_no_done_tail", burst_done, 0);
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
